// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared defaults, sample width and bit-reversal helper for the FFT output reorder buffer
package fft_reorder_pkg;
  localparam int DEF_NBITS = 2;
  localparam int DEF_LOG2N = 7;
  localparam int DEF_N = 1 << DEF_LOG2N;
  localparam int DEF_SW = 2 * DEF_NBITS;
  function automatic logic [DEF_LOG2N-1:0] bitrev(input logic [DEF_LOG2N-1:0] x);
    logic [DEF_LOG2N-1:0] r;
    for (int i = 0; i < DEF_LOG2N; i++) r[i] = x[DEF_LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame of sample storage, synchronous write and combinational read
module fft_reorder_bank import fft_reorder_pkg::*; #(
  parameter int W = DEF_SW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] wa,
  input  logic [W-1:0]     wd,
  input  logic [LOG2N-1:0] ra,
  output logic [W-1:0]     rd
);
  logic [W-1:0] mem [1<<LOG2N];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong reorder buffer turning bit-reversed FFT output into natural order
// Defining FFT_REORDER_OVF_EN adds a sticky overflow flag on port ovf.
module fft_out_reorder import fft_reorder_pkg::*; #(
  parameter int NBITS = DEF_NBITS,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*NBITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*NBITS-1:0] out_data,
  output logic               out_last
`ifdef FFT_REORDER_OVF_EN
  ,
  output logic               ovf
`endif
);
  logic [1:0] full, full_n;
  logic wb, rb;
  logic [LOG2N-1:0] wc, rc;
  logic wr_acc, rd_acc, wdone, rdone;
  logic [2*NBITS-1:0] rd0, rd1;
  assign in_ready = !full[wb];
  assign out_valid = full[rb];
  assign wr_acc = in_valid && in_ready;
  assign rd_acc = out_valid && out_ready;
  assign wdone = wr_acc && &wc;
  assign rdone = rd_acc && &rc;
  assign out_last = out_valid && &rc;
  assign out_data = out_valid ? (rb ? rd1 : rd0) : '0;
  // a completing write and a freeing read always address different banks
  always_comb begin
    full_n = full;
    if (wdone) full_n[wb] = 1'b1;
    if (rdone) full_n[rb] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      wc <= '0;
      rc <= '0;
    end else begin
      full <= full_n;
      if (wr_acc) wc <= wc + 1'b1;
      if (wdone) wb <= !wb;
      if (rd_acc) rc <= rc + 1'b1;
      if (rdone) rb <= !rb;
    end
`ifdef FFT_REORDER_OVF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf <= 1'b0;
    else if (in_valid && !in_ready) ovf <= 1'b1;
`endif
  fft_reorder_bank #(.W(2*NBITS), .LOG2N(LOG2N)) u_bank0 (
    .clk(clk), .we(wr_acc && !wb), .wa(bitrev(wc)), .wd(in_data), .ra(rc), .rd(rd0)
  );
  fft_reorder_bank #(.W(2*NBITS), .LOG2N(LOG2N)) u_bank1 (
    .clk(clk), .we(wr_acc && wb), .wa(bitrev(wc)), .wd(in_data), .ra(rc), .rd(rd1)
  );
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: randomized bench checking the reorder buffer against a frame-level bit-reversal model
module tb_fft_out_reorder;
  localparam int NBITS = 8;
  localparam int LOG2N = 7;
  localparam int N = 128;
  localparam int SW = 2 * NBITS;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [SW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [SW-1:0] out_data;
`ifdef FFT_REORDER_OVF_EN
  logic ovf;
`endif
  typedef struct {logic [SW-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  logic [SW-1:0] fr [N];
  int part = 0, checks = 0, failures = 0, tot_in = 0, tot_out = 0, gaps = 0, stalls = 0, rdy_mode = 0;
  bit gap_en = 0;
  fft_out_reorder #(.NBITS(NBITS), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef FFT_REORDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic int brev(input int j);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((j >> i) & 1);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rdy(input int m);
    rdy_mode = m;
    out_ready = (m == 2) ? 1'($urandom_range(0, 1)) : (m == 1);
  endtask
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end
  // frame model: input sample j of a frame appears at output position brev(j)
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      part = 0;
      exp_q.delete();
    end else begin
      if (gap_en && !out_valid) gaps++;
      if (!out_valid) begin
        chk("idle_data", out_data, 0);
        chk("idle_last", out_last, 0);
      end
      if (out_valid && out_ready) begin
        tot_out++;
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
      end
      if (in_valid && in_ready) begin
        fr[brev(part)] = in_data;
        part++;
        tot_in++;
        if (part == N) begin
          for (int k = 0; k < N; k++) exp_q.push_back('{d: fr[k], l: (k == N - 1)});
          part = 0;
        end
      end
    end
  end
  task automatic send(input int mode, input int n);
    int j = 0, t = 0;
    while (j < n && t < 4000) begin
      in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = (mode == 0) ? SW'(brev(part)) : SW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) j++;
      else if (in_valid) stalls++;
      t++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (t >= 4000) chk("send_timeout", 1, 0);
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
      step();
      t++;
    end
    gap_en = 0;
    chk("drain_done", t < 2000, 1);
  endtask
  task automatic pulse_rst();
    rst = 0;
    in_valid = 0;
    repeat (2) step();
    rst = 1;
    step();
  endtask
  initial begin
    int n;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
`ifdef FFT_REORDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1;
    step();
    set_rdy(1);
    send(0, N - 1);
    chk("pre_last_valid", out_valid, 0);
    send(0, 1);
    chk("lat_valid", out_valid, 1);
    chk("lat_first_last", out_last, 0);
    drain();
    chk("single_count", tot_out, N);
    tot_in = 0; tot_out = 0; stalls = 0; gaps = 0;
    send(1, N);
    gap_en = 1;
    repeat (3) send(1, N);
    drain();
    chk("b2b_stalls", stalls, 0);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_count", tot_out, 4 * N);
    tot_in = 0; tot_out = 0;
    set_rdy(0);
    send(1, 2 * N);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1;
    in_data = SW'($urandom);
    repeat (5) step();
    in_valid = 0;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_no_read", tot_out, 0);
    set_rdy(1);
    n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    chk("bp_ready_return", n, N);
    send(1, N);
    drain();
    chk("bp_count", tot_out, 3 * N);
    tot_in = 0; tot_out = 0;
    set_rdy(2);
    repeat (10) send(2, N);
    drain();
    chk("rand_count", tot_out, tot_in);
    chk("rand_total", tot_out, 10 * N);
    set_rdy(1);
    send(0, N);
    send(1, 60);
    rst = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    step();
    rst = 1;
    step();
    tot_in = 0; tot_out = 0;
    chk("post_rst_valid", out_valid, 0);
    set_rdy(2);
    send(2, N);
    drain();
    chk("post_rst_count", tot_out, N);
`ifdef FFT_REORDER_OVF_EN
    pulse_rst();
    chk("ovf_clear", ovf, 0);
    tot_in = 0; tot_out = 0;
    set_rdy(0);
    send(1, 2 * N);
    chk("ovf_pre", ovf, 0);
    in_valid = 1;
    in_data = SW'($urandom);
    step();
    in_valid = 0;
    chk("ovf_set", ovf, 1);
    repeat (3) step();
    chk("ovf_hold", ovf, 1);
    set_rdy(1);
    drain();
    chk("ovf_stream_count", tot_out, 2 * N);
    chk("ovf_sticky", ovf, 1);
    pulse_rst();
    chk("ovf_reset", ovf, 0);
`else
    pulse_rst();
    chk("final_rst_valid", out_valid, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
